// File: rtl/mips_mem_pkg.sv
// Purpose : shared encodings for the MIPS MEM stage (memop codes, FSM states, byte lanes).
// Latency : n/a (definitions only).
// Backpressure: n/a.
// Contents: MEMOP_* codes, mem_state_e, SEL_* lane masks (big-endian, bit3 = bits 31:24).
package mips_mem_pkg;

  localparam logic [3:0] MEMOP_NONE = 4'd0;
  localparam logic [3:0] MEMOP_LB   = 4'd1;
  localparam logic [3:0] MEMOP_LBU  = 4'd2;
  localparam logic [3:0] MEMOP_LH   = 4'd3;
  localparam logic [3:0] MEMOP_LHU  = 4'd4;
  localparam logic [3:0] MEMOP_LW   = 4'd5;
  localparam logic [3:0] MEMOP_SB   = 4'd6;
  localparam logic [3:0] MEMOP_SH   = 4'd7;
  localparam logic [3:0] MEMOP_SW   = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  // Byte offset 0 lives in bits 31:24, so lane masks shift right with the offset.
  localparam logic [3:0] SEL_BYTE0 = 4'b1000;
  localparam logic [3:0] SEL_HALF0 = 4'b1100;
  localparam logic [3:0] SEL_HALF1 = 4'b0011;
  localparam logic [3:0] SEL_WORD  = 4'b1111;

endpackage

// File: rtl/mem_load_ext.sv
// Purpose : align a big-endian bus word to the addressed byte/half and sign/zero extend it.
// Latency : combinational.
// Backpressure: none.
// Ports   : i_rdata raw bus word, i_off byte offset, i_memop load kind, o_data result.
module mem_load_ext
  import mips_mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [3:0]  i_memop,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_off)
      2'd0:    w_byte = i_rdata[31:24];
      2'd1:    w_byte = i_rdata[23:16];
      2'd2:    w_byte = i_rdata[15:8];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  // Halfword offset is 0 or 2 once alignment has been checked upstream.
  assign w_half = i_off[1] ? i_rdata[15:0] : i_rdata[31:16];

  always_comb begin
    o_data = i_rdata;
    case (i_memop)
      MEMOP_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      MEMOP_LBU: o_data = {24'h000000, w_byte};
      MEMOP_LH:  o_data = {{16{w_half[15]}}, w_half};
      MEMOP_LHU: o_data = {16'h0000, w_half};
      default:   o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Purpose : MIPS MEM stage; issues loads/stores on a req/ack bus and feeds MEM/WB.
// Latency : non-memory ops pass through same cycle; memory ops take >= 3 cycles (IDLE, BUSY, DONE).
// Backpressure: stall_req holds upstream while an access is pending; the bus side waits on dbus_ack.
// Ports   : ex_* EX/MEM inputs; mem_addr/mem_en/mem_data to MEM/WB; stall_req, exc_misalign;
//           dbus_* request/ack data bus; bus_err watchdog abort.
// Option  : define DBUS_TIMEOUT_EN to enable the BUSY watchdog (TIMEOUT_CYCLES); otherwise bus_err=0.
module mem_stage
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [3:0]  ex_memop,
  input  logic [31:0] ex_maddr,
  input  logic [31:0] ex_sdata,
  output logic [4:0]  mem_addr,
  output logic        mem_en,
  output logic [31:0] mem_data,
  output logic        stall_req,
  output logic        exc_misalign,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack,
  output logic        bus_err
);

  mem_state_e  r_state;
  mem_state_e  w_state_nxt;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_misalign;
  logic        w_go;
  logic        w_ack;
  logic        w_tmo;
  logic [3:0]  w_sel;
  logic [31:0] w_wdata;
  logic [31:0] w_ext;

  logic        r_dbus_req;
  logic        r_dbus_we;
  logic [31:0] r_dbus_addr;
  logic [3:0]  r_dbus_sel;
  logic [31:0] r_dbus_wdata;
  logic [31:0] r_load_res;

  // Decode op class, alignment and lane/data shaping.
  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_misalign = 1'b0;
    w_sel      = 4'b0000;
    w_wdata    = 32'h0;
    case (ex_memop)
      MEMOP_LB, MEMOP_LBU: begin
        w_is_load = 1'b1;
        w_sel     = SEL_BYTE0 >> ex_maddr[1:0];
      end
      MEMOP_LH, MEMOP_LHU: begin
        w_is_load  = 1'b1;
        w_misalign = ex_maddr[0];
        w_sel      = ex_maddr[1] ? SEL_HALF1 : SEL_HALF0;
      end
      MEMOP_LW: begin
        w_is_load  = 1'b1;
        w_misalign = |ex_maddr[1:0];
        w_sel      = SEL_WORD;
      end
      MEMOP_SB: begin
        w_is_store = 1'b1;
        w_sel      = SEL_BYTE0 >> ex_maddr[1:0];
        w_wdata    = {4{ex_sdata[7:0]}};
      end
      MEMOP_SH: begin
        w_is_store = 1'b1;
        w_misalign = ex_maddr[0];
        w_sel      = ex_maddr[1] ? SEL_HALF1 : SEL_HALF0;
        w_wdata    = {2{ex_sdata[15:0]}};
      end
      MEMOP_SW: begin
        w_is_store = 1'b1;
        w_misalign = |ex_maddr[1:0];
        w_sel      = SEL_WORD;
        w_wdata    = ex_sdata;
      end
      default: ;
    endcase
  end

  assign w_go  = (r_state == IDLE) && (w_is_load || w_is_store) && !w_misalign;
  // Acks seen outside BUSY belong to nobody and are dropped.
  assign w_ack = (r_state == BUSY) && dbus_ack;

  // EX/MEM inputs are frozen by the stall, so offset/op are still valid when the ack lands.
  mem_load_ext u_load_ext (
    .i_rdata (dbus_rdata),
    .i_off   (ex_maddr[1:0]),
    .i_memop (ex_memop),
    .o_data  (w_ext)
  );

`ifdef DBUS_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [TW-1:0] r_tmo_cnt;
  logic          r_bus_err;

  // Counter holds the number of BUSY cycles already completed; abort on the last allowed one.
  assign w_tmo = (r_state == BUSY) && !dbus_ack && (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmo_cnt <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_tmo;
      if (w_go) begin
        r_tmo_cnt <= '0;
      end else if (r_state == BUSY) begin
        r_tmo_cnt <= r_tmo_cnt + TW'(1);
      end
    end
  end

  // bus_err is high exactly during the DONE cycle that follows an abort.
  assign bus_err = r_bus_err;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
  assign w_tmo        = 1'b0;
  assign bus_err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    mem_addr     = ex_wd;
    mem_en       = 1'b0;
    mem_data     = ex_wdata;
    stall_req    = 1'b0;
    exc_misalign = 1'b0;
    case (r_state)
      IDLE: begin
        if (!(w_is_load || w_is_store)) begin
          mem_en = ex_wreg;
        end else if (w_misalign) begin
          exc_misalign = 1'b1;
        end else begin
          stall_req   = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        stall_req = 1'b1;
        if (w_ack || w_tmo) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (w_is_load) begin
          mem_en   = ex_wreg & ~bus_err;
          mem_data = r_load_res;
        end else if (!w_is_store) begin
          mem_en = ex_wreg;
        end
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dbus_req   <= 1'b0;
      r_dbus_we    <= 1'b0;
      r_dbus_addr  <= 32'h0;
      r_dbus_sel   <= 4'b0000;
      r_dbus_wdata <= 32'h0;
      r_load_res   <= 32'h0;
    end else begin
      if (w_go) begin
        r_dbus_req   <= 1'b1;
        r_dbus_we    <= w_is_store;
        r_dbus_addr  <= {ex_maddr[31:2], 2'b00};
        r_dbus_sel   <= w_sel;
        r_dbus_wdata <= w_wdata;
      end else if (w_ack || w_tmo) begin
        r_dbus_req <= 1'b0;
      end
      if (w_ack) begin
        r_load_res <= w_ext;
      end
    end
  end

  assign dbus_req   = r_dbus_req;
  assign dbus_we    = r_dbus_we;
  assign dbus_addr  = r_dbus_addr;
  assign dbus_sel   = r_dbus_sel;
  assign dbus_wdata = r_dbus_wdata;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import mips_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [3:0]  ex_memop;
  logic [31:0] ex_maddr;
  logic [31:0] ex_sdata;
  logic [4:0]  mem_addr;
  logic        mem_en;
  logic [31:0] mem_data;
  logic        stall_req;
  logic        exc_misalign;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_wdata;
  logic [31:0] dbus_rdata;
  logic        dbus_ack;
  logic        bus_err;

  int n_vec = 0;
  int n_err = 0;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_memop(ex_memop), .ex_maddr(ex_maddr), .ex_sdata(ex_sdata),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_data(mem_data),
    .stall_req(stall_req), .exc_misalign(exc_misalign),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
    .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b0; ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'h1234;
    ex_memop = MEMOP_NONE; ex_maddr = 32'h0; ex_sdata = 32'h0;
    dbus_rdata = 32'h0; dbus_ack = 1'b0;
    @(negedge clk); #1;
    n_vec++; if ({dbus_req, dbus_we, dbus_sel} !== 6'b0) begin n_err++; $display("FAIL rst_ctl got=%b exp=000000", {dbus_req, dbus_we, dbus_sel}); end
    n_vec++; if (dbus_addr !== 32'h0 || dbus_wdata !== 32'h0) begin n_err++; $display("FAIL rst_bus addr=%h wdata=%h exp=0", dbus_addr, dbus_wdata); end
    n_vec++; if (bus_err !== 1'b0 || stall_req !== 1'b0) begin n_err++; $display("FAIL rst_err err=%b stall=%b exp=0", bus_err, stall_req); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_none();
    @(negedge clk);
    ex_memop = MEMOP_NONE; ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'h1234;
    #1;
    n_vec++; if ({mem_addr, mem_en, mem_data, stall_req} !== {5'd5, 1'b1, 32'h1234, 1'b0}) begin n_err++; $display("FAIL none addr=%0d en=%b data=%h stall=%b exp 5 1 1234 0", mem_addr, mem_en, mem_data, stall_req); end
    ex_memop = 4'd12; ex_wd = 5'd7; ex_wreg = 1'b0; ex_wdata = 32'hCAFE_0001;
    #1;
    n_vec++; if ({mem_addr, mem_en, mem_data, stall_req} !== {5'd7, 1'b0, 32'hCAFE_0001, 1'b0}) begin n_err++; $display("FAIL op12 addr=%0d en=%b data=%h stall=%b exp 7 0 cafe0001 0", mem_addr, mem_en, mem_data, stall_req); end
    ex_memop = MEMOP_NONE;
    @(negedge clk); #1;
    n_vec++; if (dbus_req !== 1'b0) begin n_err++; $display("FAIL none_req got=%b exp=0", dbus_req); end
  endtask

  task automatic test_loads();
    logic [3:0]  op   [6] = '{MEMOP_LB, MEMOP_LBU, MEMOP_LH, MEMOP_LHU, MEMOP_LW, MEMOP_LB};
    logic [31:0] adr  [6] = '{32'h101, 32'h101, 32'h002, 32'h000, 32'h100, 32'h003};
    logic [31:0] rd   [6] = '{32'h11F2_3344, 32'h11F2_3344, 32'h1234_8001, 32'h8001_7FFF, 32'hDEAD_BEEF, 32'h0000_007F};
    logic [3:0]  sel  [6] = '{4'b0100, 4'b0100, 4'b0011, 4'b1100, 4'b1111, 4'b0001};
    logic [31:0] exp  [6] = '{32'hFFFF_FFF2, 32'h0000_00F2, 32'hFFFF_8001, 32'h0000_8001, 32'hDEAD_BEEF, 32'h0000_007F};
    for (int i = 0; i < 6; i++) begin
      int stalls;
      stalls = 0;
      @(negedge clk);
      ex_memop = op[i]; ex_maddr = adr[i]; ex_wd = 5'd9; ex_wreg = 1'b1; ex_wdata = 32'h0;
      #1;
      if (stall_req === 1'b1) stalls++;
      n_vec++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL ld%0d_idle_en got=%b exp=0", i, mem_en); end
      @(negedge clk);
      if (stall_req === 1'b1) stalls++;
      n_vec++; if ({dbus_req, dbus_we, dbus_sel} !== {1'b1, 1'b0, sel[i]}) begin n_err++; $display("FAIL ld%0d_bus req=%b we=%b sel=%b exp 1 0 %b", i, dbus_req, dbus_we, dbus_sel, sel[i]); end
      n_vec++; if (dbus_addr !== {adr[i][31:2], 2'b00}) begin n_err++; $display("FAIL ld%0d_addr got=%h exp=%h", i, dbus_addr, {adr[i][31:2], 2'b00}); end
      dbus_ack = 1'b1; dbus_rdata = rd[i];
      @(negedge clk);
      dbus_ack = 1'b0; dbus_rdata = 32'h0;
      #1;
      if (stall_req === 1'b1) stalls++;
      n_vec++; if ({mem_addr, mem_en, mem_data} !== {5'd9, 1'b1, exp[i]}) begin n_err++; $display("FAIL ld%0d_done addr=%0d en=%b data=%h exp 9 1 %h", i, mem_addr, mem_en, mem_data, exp[i]); end
      n_vec++; if (stalls !== 2 || dbus_req !== 1'b0) begin n_err++; $display("FAIL ld%0d_stall stalls=%0d req=%b exp 2 0", i, stalls, dbus_req); end
      ex_memop = MEMOP_NONE;
    end
  endtask

  task automatic test_stores();
    logic [3:0]  op  [3] = '{MEMOP_SH, MEMOP_SB, MEMOP_SW};
    logic [31:0] adr [3] = '{32'h202, 32'h003, 32'h0F0};
    logic [31:0] sd  [3] = '{32'h0000_ABCD, 32'h1234_565A, 32'hCAFE_F00D};
    logic [3:0]  sel [3] = '{4'b0011, 4'b0001, 4'b1111};
    logic [31:0] wd  [3] = '{32'hABCD_ABCD, 32'h5A5A_5A5A, 32'hCAFE_F00D};
    int          bcy [3] = '{3, 1, 2};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ex_memop = op[i]; ex_maddr = adr[i]; ex_sdata = sd[i]; ex_wd = 5'd3; ex_wreg = 1'b1;
      for (int c = 1; c <= bcy[i]; c++) begin
        @(negedge clk);
        n_vec++; if ({dbus_req, dbus_we, dbus_sel, mem_en, stall_req} !== {1'b1, 1'b1, sel[i], 1'b0, 1'b1}) begin n_err++; $display("FAIL st%0d_c%0d req=%b we=%b sel=%b en=%b stall=%b exp 1 1 %b 0 1", i, c, dbus_req, dbus_we, dbus_sel, mem_en, stall_req, sel[i]); end
        n_vec++; if (dbus_wdata !== wd[i] || dbus_addr !== {adr[i][31:2], 2'b00}) begin n_err++; $display("FAIL st%0d_c%0d_dat wdata=%h addr=%h exp %h %h", i, c, dbus_wdata, dbus_addr, wd[i], {adr[i][31:2], 2'b00}); end
        if (c == bcy[i]) dbus_ack = 1'b1;
      end
      @(negedge clk);
      dbus_ack = 1'b0;
      #1;
      n_vec++; if ({mem_en, stall_req, dbus_req} !== 3'b000) begin n_err++; $display("FAIL st%0d_done en=%b stall=%b req=%b exp 0 0 0", i, mem_en, stall_req, dbus_req); end
      ex_memop = MEMOP_NONE;
    end
  endtask

  task automatic test_misalign();
    logic [3:0]  op  [4] = '{MEMOP_LW, MEMOP_LH, MEMOP_SH, MEMOP_SW};
    logic [31:0] adr [4] = '{32'h103, 32'h101, 32'h201, 32'h102};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ex_memop = op[i]; ex_maddr = adr[i]; ex_wreg = 1'b1;
      #1;
      n_vec++; if ({exc_misalign, stall_req, mem_en} !== 3'b100) begin n_err++; $display("FAIL mis%0d exc=%b stall=%b en=%b exp 1 0 0", i, exc_misalign, stall_req, mem_en); end
      @(negedge clk); @(negedge clk);
      n_vec++; if (dbus_req !== 1'b0) begin n_err++; $display("FAIL mis%0d_req got=%b exp=0", i, dbus_req); end
    end
    ex_memop = MEMOP_NONE;
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    ex_memop = MEMOP_LW; ex_maddr = 32'h100; ex_wreg = 1'b1;
    @(negedge clk);
    n_vec++; if (dbus_req !== 1'b1) begin n_err++; $display("FAIL rmid_busy req=%b exp=1", dbus_req); end
    #1 reset = 1'b0;
    #1;
    n_vec++; if (dbus_req !== 1'b0 || dbus_sel !== 4'b0000) begin n_err++; $display("FAIL rmid_abort req=%b sel=%b exp 0 0000", dbus_req, dbus_sel); end
    ex_memop = MEMOP_NONE;
    @(negedge clk);
    reset = 1'b1; dbus_ack = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dbus_ack = 1'b0;
    #1;
    n_vec++; if (dbus_req !== 1'b0 || stall_req !== 1'b0) begin n_err++; $display("FAIL rmid_ack req=%b stall=%b exp 0 0", dbus_req, stall_req); end
    // Only IDLE raises stall with mem_en low for a fresh aligned op.
    ex_memop = MEMOP_LW;
    #1;
    n_vec++; if ({stall_req, mem_en} !== 2'b10) begin n_err++; $display("FAIL rmid_idle stall=%b en=%b exp 1 0", stall_req, mem_en); end
    ex_memop = MEMOP_NONE;
  endtask

  task automatic test_timeout();
    @(negedge clk);
    ex_memop = MEMOP_LW; ex_maddr = 32'h010; ex_wd = 5'd4; ex_wreg = 1'b1;
`ifdef DBUS_TIMEOUT_EN
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      n_vec++; if ({dbus_req, bus_err, stall_req} !== 3'b101) begin n_err++; $display("FAIL tmo_c%0d req=%b err=%b stall=%b exp 1 0 1", c, dbus_req, bus_err, stall_req); end
    end
    @(negedge clk);
    n_vec++; if ({dbus_req, bus_err, stall_req, mem_en} !== 4'b0100) begin n_err++; $display("FAIL tmo_done req=%b err=%b stall=%b en=%b exp 0 1 0 0", dbus_req, bus_err, stall_req, mem_en); end
    ex_memop = MEMOP_NONE;
    @(negedge clk);
    n_vec++; if ({bus_err, dbus_req} !== 2'b00) begin n_err++; $display("FAIL tmo_idle err=%b req=%b exp 0 0", bus_err, dbus_req); end
`else
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      n_vec++; if ({dbus_req, bus_err, stall_req} !== 3'b101) begin n_err++; $display("FAIL hold_c%0d req=%b err=%b stall=%b exp 1 0 1", c, dbus_req, bus_err, stall_req); end
    end
    dbus_ack = 1'b1; dbus_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    dbus_ack = 1'b0;
    #1;
    n_vec++; if ({mem_en, mem_data, bus_err} !== {1'b1, 32'h0BAD_F00D, 1'b0}) begin n_err++; $display("FAIL hold_done en=%b data=%h err=%b exp 1 0badf00d 0", mem_en, mem_data, bus_err); end
    ex_memop = MEMOP_NONE;
`endif
  endtask

  initial begin
    test_reset();
    test_none();
    test_loads();
    test_stores();
    test_misalign();
    test_reset_mid_access();
    test_timeout();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
